// File: rtl/ddr_stream_wr_dma_if.sv
// Bus bundle for ddr_stream_wr_dma.
// Groups the three buses the DMA sits on:
//   st_sink_* : Avalon-ST sink (stream samples in)
//   mm_*      : Avalon-MM burst write master (towards the EMIF slave)
//   csr_*     : 32-bit Avalon-MM CSR slave, plus the level interrupt
// Modports:
//   master : the DMA side (drives ready, the MM write master and CSR read data / irq)
//   slave  : the system side (stream source, memory slave, CSR host)
interface ddr_stream_wr_dma_if #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BURST_W = 7
);
  logic [DATA_W-1:0]   st_sink_data;
  logic                st_sink_valid;
  logic                st_sink_ready;

  logic [ADDR_W-1:0]   mm_address;
  logic                mm_write;
  logic [DATA_W-1:0]   mm_writedata;
  logic [DATA_W/8-1:0] mm_byteenable;
  logic [BURST_W-1:0]  mm_burstcount;
  logic                mm_waitrequest;

  logic [2:0]          csr_address;
  logic                csr_read;
  logic                csr_write;
  logic [31:0]         csr_writedata;
  logic [31:0]         csr_readdata;
  logic                irq;

  modport master (
    input  st_sink_data, st_sink_valid, mm_waitrequest,
    input  csr_address, csr_read, csr_write, csr_writedata,
    output st_sink_ready, mm_address, mm_write, mm_writedata, mm_byteenable, mm_burstcount,
    output csr_readdata, irq
  );

  modport slave (
    output st_sink_data, st_sink_valid, mm_waitrequest,
    output csr_address, csr_read, csr_write, csr_writedata,
    input  st_sink_ready, mm_address, mm_write, mm_writedata, mm_byteenable, mm_burstcount,
    input  csr_readdata, irq
  );
endinterface

// File: rtl/ddr_stream_wr_dma.sv
// Avalon-ST to Avalon-MM write DMA into a DDR buffer.
// Stream beats are buffered in a FIFO; once enough beats are present a burst of up to
// MAX_BURST beats is written at base + offset. Single mode stops after LENGTH bytes; ring mode
// wraps back to base and counts wraps until software issues stop, which flushes the FIFO.
// Ports:
//   in_clk_clk     : sole clock
//   in_reset_reset : asynchronous active-high reset
//   dma_if         : stream sink, MM burst master, CSR slave and irq (master modport)
// CSR map (word addresses): 0 CTRL, 1 BASE, 2 LENGTH, 3 STATUS, 4 WR_OFFSET, 5 WRAP_COUNT.
module ddr_stream_wr_dma #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_W    = 7,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic                 in_clk_clk,
  input  logic                 in_reset_reset,
  ddr_stream_wr_dma_if.master  dma_if
);
  localparam int unsigned BEAT_B    = DATA_W / 8;
  localparam int unsigned BEAT_SH   = $clog2(BEAT_B);
  localparam int unsigned MAX_BURST = 2 ** (BURST_W - 1);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

  state_e state_q, state_d;

  // Software-visible registers
  logic               ring_q, ring_d;
  logic               irq_en_q, irq_en_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        length_q, length_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic [31:0]        wr_offset_q, wr_offset_d;
  logic [31:0]        wrap_count_q, wrap_count_d;
  logic [31:0]        rdata_q, rdata_d;

  // Job state, latched at start so CSR writes while busy do not disturb the run
  logic [ADDR_W-1:0]  job_base_q, job_base_d;
  logic [ADDR_W-1:0]  burst_addr_q, burst_addr_d;
  logic [31:0]        total_beats_q, total_beats_d;
  logic [31:0]        remaining_q, remaining_d;
  logic [BURST_W-1:0] blen_q, blen_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic               stopping_q, stopping_d;

  // Stream FIFO
  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               busy, fifo_full, sink_ready, push, beat_done, last_beat;
  logic               start_req, stop_req, len_ok;
  logic [BURST_W-1:0] norm_blen;
  logic [31:0]        rem_after;

  assign busy       = (state_q == StWait) || (state_q == StBurst);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign sink_ready = busy && !fifo_full && !stopping_q;
  assign push       = dma_if.st_sink_valid && sink_ready;
  assign beat_done  = (state_q == StBurst) && !dma_if.mm_waitrequest;
  assign last_beat  = beat_done && (beat_cnt_q == blen_q - BURST_W'(1));
  assign rem_after  = remaining_q - 32'(blen_q);

  assign start_req  = dma_if.csr_write && (dma_if.csr_address == 3'd0) && dma_if.csr_writedata[0];
  assign stop_req   = dma_if.csr_write && (dma_if.csr_address == 3'd0) && dma_if.csr_writedata[3];
  assign len_ok     = (length_q != 32'd0) && (length_q[BEAT_SH-1:0] == '0) &&
                      (length_q >= 32'(BEAT_B));

  // Bursts are capped by what is left of the buffer so they never cross its end.
  assign norm_blen  = (remaining_q >= 32'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                      : remaining_q[BURST_W-1:0];

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (beat_done ? PTR_W'(1) : PTR_W'(0));
    count_d  = count_q + CNT_W'(push) - CNT_W'(beat_done);
  end

  always_ff @(posedge in_clk_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= dma_if.st_sink_data;
    end
  end

  // CSR access and DMA control FSM
  always_comb begin
    state_d       = state_q;
    ring_d        = ring_q;
    irq_en_d      = irq_en_q;
    base_d        = base_q;
    length_d      = length_q;
    done_d        = done_q;
    cfg_err_d     = cfg_err_q;
    wr_offset_d   = wr_offset_q;
    wrap_count_d  = wrap_count_q;
    rdata_d       = 32'd0;
    job_base_d    = job_base_q;
    burst_addr_d  = burst_addr_q;
    total_beats_d = total_beats_q;
    remaining_d   = remaining_q;
    blen_d        = blen_q;
    beat_cnt_d    = beat_cnt_q;
    stopping_d    = stopping_q;

    if (dma_if.csr_write) begin
      case (dma_if.csr_address)
        3'd0: begin
          ring_d   = dma_if.csr_writedata[1];
          irq_en_d = dma_if.csr_writedata[2];
        end
        3'd1: base_d   = dma_if.csr_writedata;
        3'd2: length_d = dma_if.csr_writedata;
        3'd3: begin
          if (dma_if.csr_writedata[1]) done_d    = 1'b0;
          if (dma_if.csr_writedata[2]) cfg_err_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (dma_if.csr_read) begin
      case (dma_if.csr_address)
        3'd0:    rdata_d = {29'd0, irq_en_q, ring_q, 1'b0};
        3'd1:    rdata_d = base_q;
        3'd2:    rdata_d = length_q;
        3'd3:    rdata_d = {29'd0, cfg_err_q, done_q, busy};
        3'd4:    rdata_d = wr_offset_q;
        3'd5:    rdata_d = wrap_count_q;
        default: rdata_d = 32'd0;
      endcase
    end

    if (busy && stop_req) begin
      stopping_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          if (!len_ok) begin
            cfg_err_d = 1'b1;
          end else begin
            job_base_d    = ADDR_W'(base_q & ~32'(BEAT_B - 1));
            total_beats_d = length_q >> BEAT_SH;
            remaining_d   = length_q >> BEAT_SH;
            wr_offset_d   = 32'd0;
            wrap_count_d  = 32'd0;
            stopping_d    = 1'b0;
            state_d       = StWait;
          end
        end
      end
      StWait: begin
        if (32'(count_q) >= 32'(norm_blen)) begin
          blen_d       = norm_blen;
          burst_addr_d = job_base_q + ADDR_W'(wr_offset_q);
          beat_cnt_d   = '0;
          state_d      = StBurst;
        end else if (stopping_q && (count_q != '0)) begin
          // Flush: count is below norm_blen here, so it fits the burst and the buffer.
          blen_d       = BURST_W'(count_q);
          burst_addr_d = job_base_q + ADDR_W'(wr_offset_q);
          beat_cnt_d   = '0;
          state_d      = StBurst;
        end else if (stopping_q) begin
          state_d      = StDone;
        end
      end
      StBurst: begin
        if (beat_done) begin
          wr_offset_d = wr_offset_q + 32'(BEAT_B);
          beat_cnt_d  = beat_cnt_q + BURST_W'(1);
        end
        if (last_beat) begin
          if (rem_after != 32'd0) begin
            remaining_d = rem_after;
            state_d     = StWait;
          end else if (ring_q) begin
            wr_offset_d  = 32'd0;
            remaining_d  = total_beats_q;
            wrap_count_d = (wrap_count_q == 32'hFFFF_FFFF) ? wrap_count_q
                                                           : wrap_count_q + 32'd1;
            state_d      = StWait;
          end else begin
            remaining_d = 32'd0;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        done_d     = 1'b1;
        stopping_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk_clk or posedge in_reset_reset) begin
    if (in_reset_reset) begin
      state_q       <= StIdle;
      ring_q        <= 1'b0;
      irq_en_q      <= 1'b0;
      base_q        <= 32'd0;
      length_q      <= 32'd0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      wr_offset_q   <= 32'd0;
      wrap_count_q  <= 32'd0;
      rdata_q       <= 32'd0;
      job_base_q    <= '0;
      burst_addr_q  <= '0;
      total_beats_q <= 32'd0;
      remaining_q   <= 32'd0;
      blen_q        <= '0;
      beat_cnt_q    <= '0;
      stopping_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      ring_q        <= ring_d;
      irq_en_q      <= irq_en_d;
      base_q        <= base_d;
      length_q      <= length_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      wr_offset_q   <= wr_offset_d;
      wrap_count_q  <= wrap_count_d;
      rdata_q       <= rdata_d;
      job_base_q    <= job_base_d;
      burst_addr_q  <= burst_addr_d;
      total_beats_q <= total_beats_d;
      remaining_q   <= remaining_d;
      blen_q        <= blen_d;
      beat_cnt_q    <= beat_cnt_d;
      stopping_q    <= stopping_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Outputs. Bus fields are gated by mm_write so everything reads 0 outside a burst and in reset;
  // byteenable is all ones on every write beat.
  always_comb begin
    dma_if.st_sink_ready = sink_ready;
    dma_if.mm_write      = (state_q == StBurst);
    dma_if.mm_address    = dma_if.mm_write ? burst_addr_q : '0;
    dma_if.mm_burstcount = dma_if.mm_write ? blen_q : '0;
    dma_if.mm_writedata  = dma_if.mm_write ? fifo_mem[rd_ptr_q] : '0;
    dma_if.mm_byteenable = {BEAT_B{dma_if.mm_write}};
    dma_if.csr_readdata  = rdata_q;
    dma_if.irq           = irq_en_q && done_q;
  end
endmodule

// File: tb/tb_ddr_stream_wr_dma.sv
// Self-checking bench for ddr_stream_wr_dma (DATA_W=128, 16-byte beats, bursts up to 64).
// Stimulus pushes expected bursts and stream beats into queues; a monitor pops and compares
// whenever the DUT writes on the MM bus.
module tb_ddr_stream_wr_dma;
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BURST_W    = 7;
  localparam int unsigned FIFO_DEPTH = 128;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  cnt;
  } burst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ddr_stream_wr_dma_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) dma_if ();

  ddr_stream_wr_dma #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .in_clk_clk(clk),
    .in_reset_reset(rst),
    .dma_if(dma_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mon_bursts = 0;
  int mon_beat = 0;
  bit mon_in_burst = 1'b0;
  int unsigned seq = 0;
  bit force_wr = 1'b0;
  bit rand_wr = 1'b0;

  burst_t      exp_burst_q[$];
  logic [127:0] exp_data_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    checks++;
    failures++;
    $display("FAIL %s: got %s, required %s", name, act, req);
  endtask

  function automatic logic [127:0] mk_data(input logic [31:0] s);
    return {s, ~s, s ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + s};
  endfunction

  task automatic exp_burst(input logic [31:0] a, input int c);
    burst_t b;
    b.addr = a;
    b.cnt  = 8'(c);
    exp_burst_q.push_back(b);
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    dma_if.csr_address   = a;
    dma_if.csr_writedata = d;
    dma_if.csr_write     = 1'b1;
    @(posedge clk); #1;
    dma_if.csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    dma_if.csr_address = a;
    dma_if.csr_read    = 1'b1;
    @(posedge clk); #1;
    dma_if.csr_read    = 1'b0;
    d = dma_if.csr_readdata;
  endtask

  task automatic csr_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_rd(a, d);
    chk(name, 128'(d), 128'(exp));
  endtask

  // Offer n beats; each accepted beat's data becomes an expected MM write beat.
  task automatic stream(input int n, input bit gaps);
    logic [127:0] d;
    int budget;
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        dma_if.st_sink_valid = 1'b0;
        @(posedge clk); #1;
      end
      d = mk_data(seq);
      seq++;
      dma_if.st_sink_valid = 1'b1;
      dma_if.st_sink_data  = d;
      ok = 1'b0;
      budget = 2000;
      while (!ok && budget > 0) begin
        @(negedge clk);
        if (dma_if.st_sink_ready) begin
          exp_data_q.push_back(d);
          ok = 1'b1;
        end
        @(posedge clk); #1;
        budget--;
      end
      if (!ok) begin
        fail_now("stream_accept", "timeout", "beat accepted");
        dma_if.st_sink_valid = 1'b0;
        return;
      end
    end
    dma_if.st_sink_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 3000 && !idle; k++) begin
      csr_rd(3'd3, s);
      if (!s[0]) idle = 1'b1;
    end
    if (!idle) fail_now(name, "busy", "idle");
  endtask

  // Memory-side waitrequest
  initial begin : wr_drv
    dma_if.mm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      dma_if.mm_waitrequest = force_wr ? 1'b1 : (rand_wr ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  end

  // Monitor: checks every MM write cycle against the expectation queues.
  initial begin : monitor
    logic [31:0] cur_addr;
    logic [6:0]  cur_cnt;
    int left;
    burst_t e;
    logic [127:0] ed;
    left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_in_burst = 1'b0;
        mon_beat = 0;
      end else if (dma_if.mm_write) begin
        if (!mon_in_burst) begin
          mon_bursts++;
          if (exp_burst_q.size() == 0) begin
            fail_now("unexpected_burst", $sformatf("0x%0h", dma_if.mm_address), "no burst");
          end else begin
            e = exp_burst_q.pop_front();
            chk("burst_addr", 128'(dma_if.mm_address), 128'(e.addr));
            chk("burst_count", 128'(dma_if.mm_burstcount), 128'(e.cnt));
          end
          cur_addr = dma_if.mm_address;
          cur_cnt  = dma_if.mm_burstcount;
          left = int'(dma_if.mm_burstcount);
          mon_in_burst = 1'b1;
          mon_beat = 0;
        end else begin
          chk("addr_stable", 128'(dma_if.mm_address), 128'(cur_addr));
          chk("count_stable", 128'(dma_if.mm_burstcount), 128'(cur_cnt));
        end
        if (!dma_if.mm_waitrequest) begin
          chk("byteenable", 128'(dma_if.mm_byteenable), 128'(16'hFFFF));
          if (exp_data_q.size() == 0) begin
            fail_now("unexpected_beat", $sformatf("0x%0h", dma_if.mm_writedata), "no beat");
          end else begin
            ed = exp_data_q.pop_front();
            chk("beat_data", dma_if.mm_writedata, ed);
          end
          mon_beat++;
          left--;
          if (left <= 0) mon_in_burst = 1'b0;
        end
      end else if (mon_in_burst) begin
        fail_now("write_dropped", "mm_write=0", "mm_write=1 until burst ends");
        mon_in_burst = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    fail_now("global_timeout", "still running", "finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bursts_before;
    bit ok;
    logic [31:0] bad_len [3];
    bad_len[0] = 32'h18;
    bad_len[1] = 32'h0;
    bad_len[2] = 32'h8;

    dma_if.st_sink_valid = 1'b0;
    dma_if.st_sink_data  = '0;
    dma_if.csr_address   = 3'd0;
    dma_if.csr_read      = 1'b0;
    dma_if.csr_write     = 1'b0;
    dma_if.csr_writedata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mm_write", 128'(dma_if.mm_write), 128'(0));
    chk("rst_ready", 128'(dma_if.st_sink_ready), 128'(0));
    chk("rst_irq", 128'(dma_if.irq), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) csr_chk($sformatf("rst_csr%0d", a), 3'(a), 32'd0);

    // 1: 4 KiB single shot, full rate
    csr_wr(3'd1, 32'h1000_0000);
    csr_wr(3'd2, 32'h1000);
    for (int k = 0; k < 4; k++) exp_burst(32'h1000_0000 + 32'(k) * 32'h400, 64);
    csr_wr(3'd0, 32'h5);
    csr_chk("t1_ctrl_selfclear", 3'd0, 32'h4);
    fork
      stream(256, 1'b0);
      wait_idle("t1_idle");
    join
    csr_chk("t1_status", 3'd3, 32'h2);
    chk("t1_irq", 128'(dma_if.irq), 128'(1));
    csr_chk("t1_wr_offset", 3'd4, 32'h1000);
    csr_chk("t1_addr6", 3'd6, 32'd0);
    chk("t1_bursts_left", 128'(exp_burst_q.size()), 128'(0));
    csr_wr(3'd3, 32'h2);

    // 2: 0x500 bytes -> 64 + 16, irq disabled
    csr_wr(3'd1, 32'h2000_0000);
    csr_wr(3'd2, 32'h500);
    exp_burst(32'h2000_0000, 64);
    exp_burst(32'h2000_0400, 16);
    csr_wr(3'd0, 32'h1);
    fork
      stream(80, 1'b0);
      wait_idle("t2_idle");
    join
    csr_chk("t2_status", 3'd3, 32'h2);
    chk("t2_irq_masked", 128'(dma_if.irq), 128'(0));
    csr_chk("t2_wr_offset", 3'd4, 32'h500);
    chk("t2_bursts_left", 128'(exp_burst_q.size()), 128'(0));
    csr_wr(3'd3, 32'h2);

    // 3: ring of 0x200 bytes, 80 beats then stop
    csr_wr(3'd1, 32'h3000_0000);
    csr_wr(3'd2, 32'h200);
    exp_burst(32'h3000_0000, 32);
    exp_burst(32'h3000_0000, 32);
    exp_burst(32'h3000_0000, 16);
    csr_wr(3'd0, 32'h7);
    stream(80, 1'b0);
    csr_wr(3'd0, 32'hE);
    wait_idle("t3_idle");
    csr_chk("t3_status", 3'd3, 32'h2);
    csr_chk("t3_wrap_count", 3'd5, 32'd2);
    csr_chk("t3_wr_offset", 3'd4, 32'h100);
    chk("t3_bursts_left", 128'(exp_burst_q.size()), 128'(0));
    csr_wr(3'd3, 32'h2);

    // 4: fill the FIFO under a stalled slave, then random stalls and source gaps
    csr_wr(3'd1, 32'h4000_0000);
    csr_wr(3'd2, 32'h2000);
    for (int k = 0; k < 8; k++) exp_burst(32'h4000_0000 + 32'(k) * 32'h400, 64);
    force_wr = 1'b1;
    csr_wr(3'd0, 32'h1);
    stream(128, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_ready_full", 128'(dma_if.st_sink_ready), 128'(0));
    force_wr = 1'b0;
    rand_wr = 1'b1;
    fork
      stream(384, 1'b1);
      wait_idle("t4_idle");
    join
    rand_wr = 1'b0;
    csr_chk("t4_status", 3'd3, 32'h2);
    csr_chk("t4_wr_offset", 3'd4, 32'h2000);
    chk("t4_bursts_left", 128'(exp_burst_q.size()), 128'(0));
    chk("t4_beats_left", 128'(exp_data_q.size()), 128'(0));
    csr_wr(3'd3, 32'h2);

    // 5: bad lengths, start while busy, W1C
    for (int i = 0; i < 3; i++) begin
      bursts_before = mon_bursts;
      csr_wr(3'd2, bad_len[i]);
      csr_wr(3'd0, 32'h5);
      repeat (4) @(posedge clk);
      csr_chk($sformatf("t5_cfg_err%0d", i), 3'd3, 32'h4);
      chk($sformatf("t5_no_write%0d", i), 128'(mon_bursts), 128'(bursts_before));
      csr_wr(3'd3, 32'h4);
      csr_chk($sformatf("t5_err_clear%0d", i), 3'd3, 32'h0);
    end
    csr_wr(3'd1, 32'h5000_0000);
    csr_wr(3'd2, 32'h400);
    exp_burst(32'h5000_0000, 64);
    csr_wr(3'd0, 32'h5);
    csr_wr(3'd1, 32'h6000_0000);
    csr_wr(3'd2, 32'h800);
    csr_wr(3'd0, 32'h5);
    fork
      stream(64, 1'b0);
      wait_idle("t5_idle");
    join
    csr_chk("t5_status", 3'd3, 32'h2);
    chk("t5_irq", 128'(dma_if.irq), 128'(1));
    csr_chk("t5_base_stored", 3'd1, 32'h6000_0000);
    csr_chk("t5_wr_offset", 3'd4, 32'h400);
    chk("t5_bursts_left", 128'(exp_burst_q.size()), 128'(0));
    csr_wr(3'd3, 32'h2);
    csr_chk("t5_w1c_status", 3'd3, 32'h0);
    chk("t5_w1c_irq", 128'(dma_if.irq), 128'(0));

    // 6: reset mid-burst, then a clean rerun
    csr_wr(3'd1, 32'h7000_0000);
    csr_wr(3'd2, 32'h400);
    exp_burst(32'h7000_0000, 64);
    csr_wr(3'd0, 32'h5);
    stream(64, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(posedge clk);
      if (mon_in_burst && mon_beat >= 10) ok = 1'b1;
    end
    if (!ok) fail_now("t6_reach_beat10", "timeout", "beat 10 of burst");
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_mm_write", 128'(dma_if.mm_write), 128'(0));
    chk("t6_rst_addr", 128'(dma_if.mm_address), 128'(0));
    chk("t6_rst_count", 128'(dma_if.mm_burstcount), 128'(0));
    chk("t6_rst_wdata", dma_if.mm_writedata, 128'(0));
    chk("t6_rst_be", 128'(dma_if.mm_byteenable), 128'(0));
    chk("t6_rst_ready", 128'(dma_if.st_sink_ready), 128'(0));
    chk("t6_rst_irq", 128'(dma_if.irq), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    exp_burst_q.delete();
    exp_data_q.delete();
    rst = 1'b0;
    csr_chk("t6_status_after_rst", 3'd3, 32'h0);
    csr_chk("t6_base_after_rst", 3'd1, 32'h0);
    csr_wr(3'd1, 32'h7000_0000);
    csr_wr(3'd2, 32'h400);
    exp_burst(32'h7000_0000, 64);
    csr_wr(3'd0, 32'h5);
    fork
      stream(64, 1'b0);
      wait_idle("t6_idle");
    join
    csr_chk("t6_status", 3'd3, 32'h2);
    csr_chk("t6_wr_offset", 3'd4, 32'h400);
    chk("t6_bursts_left", 128'(exp_burst_q.size()), 128'(0));
    chk("t6_beats_left", 128'(exp_data_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
